// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An access is rejected when it is not word aligned or lies past the last word.
  function automatic logic access_err(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-lane write, combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Write only the byte lanes whose strobe is set.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [STRB_W-1:0] req_wstrb,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              enter_resp;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic [STRB_W-1:0] cur_wstrb;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // With zero wait states RESP is entered on the accept edge itself, so the
  // commit must use the live request; otherwise it uses the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = req_addr;
      cur_we    = req_we;
      cur_wstrb = req_wstrb;
      cur_wdata = req_wdata;
    end else begin
      cur_addr  = addr_q;
      cur_we    = we_q;
      cur_wstrb = wstrb_q;
      cur_wdata = wdata_q;
    end
    cur_err = access_err(cur_addr, DEPTH_WORDS);
  end

  // Store commits on the edge entering RESP; a concurrent reset suppresses it.
  assign mem_we = enter_resp & cur_we & ~cur_err & ~rst;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (cur_addr[IDX_W+1:2]),
    .wstrb_i (cur_wstrb),
    .wdata_i (cur_wdata),
    .rdata_o (mem_rdata)
  );

  // Next-state, request capture and response formation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_we) ? '0 : mem_rdata;
    end
  end

  // State and captured-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance (index 0) and a
// WAIT_CYCLES=0 instance (index 1) checked against a word-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [31:0] resp_rdata [2];
  logic [3:0]  req_wstrb  [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] model [2][256];
  int          exp_lat [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_we(req_we[0]), .req_wstrb(req_wstrb[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_we(req_we[1]), .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[0+1])
  );

  // Reference: error rule, byte-lane merge on store, word read on load.
  function automatic void ref_access(input int d, input bit we, input logic [31:0] a,
                                     input logic [3:0] s, input logic [31:0] wd,
                                     output logic [31:0] erd, output bit eerr);
    eerr = (a % 4 != 0) || (a / 4 >= 256);
    erd  = 32'h0;
    if (!eerr) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) model[d][a[9:2]][8*i +: 8] = wd[8*i +: 8];
      end else begin
        erd = model[d][a[9:2]];
      end
    end
  endfunction

  // Drives one transaction; entered and left just after a negedge.
  task automatic txn(input int d, input bit we, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output bit er, output int lat,
                     output bit stable, output bit quiet, output bit rdy_after,
                     output bit tmo, output int acc_cyc, output int hs_cyc);
    int n;
    n = 0;
    tmo = 1'b0; stable = 1'b1; quiet = 1'b1;
    while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
    if (!req_ready[d]) tmo = 1'b1;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
    req_wstrb[d] = s; req_wdata[d] = wd;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 40) begin
      if (resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0 || req_ready[d] !== 1'b0) quiet = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!resp_valid[d]) tmo = 1'b1;
    rd = resp_rdata[d];
    er = resp_err[d];
    if (req_ready[d] !== 1'b0) stable = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== rd || resp_err[d] !== er ||
          req_ready[d] !== 1'b0) stable = 1'b0;
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc;
    resp_ready[d] = 1'b0;
    rdy_after = (req_ready[d] === 1'b1) && (resp_valid[d] === 1'b0) &&
                (resp_rdata[d] === 32'h0) && (resp_err[d] === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wstrb[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
          resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state dut%0d: got rdy=%b vld=%b rdata=%h err=%b, want rdy=1 vld=0 rdata=0 err=0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One transaction on dut d with every response property checked against the model.
  task automatic checked_txn(input string nm, input int d, input bit we, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] wd, input int hold);
    logic [31:0] rd, erd;
    bit er, eer, st, qu, ra, tmo;
    int lat, ac, hc;
    ref_access(d, we, a, s, wd, erd, eer);
    txn(d, we, a, s, wd, hold, rd, er, lat, st, qu, ra, tmo, ac, hc);
    total++;
    if (tmo) begin bad++; $display("FAIL %s timeout: no handshake/response within bound", nm); end
    total++;
    if (rd !== erd || er !== eer) begin
      bad++;
      $display("FAIL %s data: got rdata=%h err=%b, want rdata=%h err=%b (addr=%h we=%b)", nm, rd, er, erd, eer, a, we);
    end
    total++;
    if (lat !== exp_lat[d]) begin bad++; $display("FAIL %s latency: got %0d, want %0d", nm, lat, exp_lat[d]); end
    total++;
    if (!st || !qu || !ra) begin
      bad++;
      $display("FAIL %s protocol: stable=%b quiet=%b ready_after=%b, want all 1", nm, st, qu, ra);
    end
  endtask

  task automatic test_store_load();
    checked_txn("store_0x10", 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0);
    checked_txn("load_0x10", 0, 1'b0, 32'h10, 4'h0, 32'h0, 0);
    total++;
    if (model[0][4] !== 32'hDEADBEEF) begin bad++; $display("FAIL store_load_model: got %h want deadbeef", model[0][4]); end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; bit er, st, qu, ra, tmo; int lat, ac, hc;
    checked_txn("preload_0x0", 0, 1'b1, 32'h0, 4'hF, 32'h11223344, 0);
    checked_txn("partial_0x0", 0, 1'b1, 32'h0, 4'h2, 32'h0000AA00, 0);
    txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 0, rd, er, lat, st, qu, ra, tmo, ac, hc);
    total++;
    if (rd !== 32'h1122AA44 || er !== 1'b0) begin
      bad++; $display("FAIL partial_load: got rdata=%h err=%b, want 1122aa44 err=0", rd, er);
    end
    checked_txn("strb0_store", 0, 1'b1, 32'h10, 4'h0, 32'h12345678, 1);
    checked_txn("strb0_load", 0, 1'b0, 32'h10, 4'h0, 32'h0, 0);
  endtask

  task automatic test_errors();
    checked_txn("err_misaligned", 0, 1'b0, 32'h3, 4'h0, 32'h0, 0);
    checked_txn("err_range_store", 0, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 0);
    checked_txn("err_after_load0", 0, 1'b0, 32'h0, 4'h0, 32'h0, 0);
    checked_txn("err_misaligned_store", 0, 1'b1, 32'h12, 4'hF, 32'h0BADF00D, 0);
    checked_txn("err_after_load10", 0, 1'b0, 32'h10, 4'h0, 32'h0, 0);
  endtask

  task automatic test_backpressure();
    checked_txn("backpressure", 0, 1'b0, 32'h10, 4'h0, 32'h0, 5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; bit er, st, qu, ra, tmo; int lat, ac1, hc1, ac2, hc2;
    logic [31:0] erd; bit eer;
    ref_access(0, 1'b1, 32'h24, 4'hF, 32'hA5A50F0F, erd, eer);
    txn(0, 1'b1, 32'h24, 4'hF, 32'hA5A50F0F, 0, rd, er, lat, st, qu, ra, tmo, ac1, hc1);
    txn(0, 1'b0, 32'h24, 4'h0, 32'h0, 0, rd, er, lat, st, qu, ra, tmo, ac2, hc2);
    total++;
    if (ac2 - hc1 !== 1) begin bad++; $display("FAIL back_to_back_gap: got %0d cycles, want 1", ac2 - hc1); end
    total++;
    if (rd !== 32'hA5A50F0F || er !== 1'b0 || tmo) begin
      bad++; $display("FAIL back_to_back_data: got rdata=%h err=%b tmo=%b, want a5a50f0f 0 0", rd, er, tmo);
    end
  endtask

  task automatic test_reset_in_wait();
    bit quiet_ok;
    checked_txn("rstwait_prior", 0, 1'b1, 32'h20, 4'hF, 32'h01020304, 0);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wstrb[0] = 4'hF; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    total++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL rstwait_in_wait: got vld=%b rdy=%b, want 0 0", resp_valid[0], req_ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL rstwait_idle: got rdy=%b want 1", req_ready[0]); end
    quiet_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) quiet_ok = 1'b0;
    end
    total++;
    if (!quiet_ok) begin bad++; $display("FAIL rstwait_no_resp: got a response after reset, want none"); end
    checked_txn("rstwait_load", 0, 1'b0, 32'h20, 4'h0, 32'h0, 0);
  endtask

  task automatic test_zero_wait();
    checked_txn("zw_store", 1, 1'b1, 32'h40, 4'hF, 32'h5A5AA5A5, 0);
    checked_txn("zw_partial", 1, 1'b1, 32'h40, 4'h9, 32'h11FFFF22, 2);
    checked_txn("zw_load", 1, 1'b0, 32'h40, 4'h0, 32'h0, 0);
    checked_txn("zw_err", 1, 1'b1, 32'h401, 4'hF, 32'h0, 0);
    checked_txn("zw_load_after_err", 1, 1'b0, 32'h40, 4'h0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int k;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        checked_txn("rand_init", d, 1'b1, 32'(w * 4), 4'hF, $urandom, 0);
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      if (k <= 6)      a = 32'($urandom_range(0, 15) * 4);
      else if (k == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (k == 8) a = 32'($urandom_range(256, 4096) * 4);
      else             a = $urandom;
      checked_txn("random", t % 2, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)),
                  $urandom, $urandom_range(0, 3));
    end
  endtask

  initial begin
    exp_lat[0] = 3;
    exp_lat[1] = 1;
    @(negedge clk);
    test_reset();
    test_store_load();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    test_zero_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
